// File: rtl/uart_frac_baud_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_frac_baud_gen_if
// Brief     : Control and tick bundle of the fractional baud tick generator.
// Revision  : 1.0 - initial release
// ============================================================================
interface uart_frac_baud_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 8
) ();
  localparam int c_ph_w = (OVS > 1) ? $clog2(OVS) : 1;

  logic              en_i;
  logic [DIV_W-1:0]  div_int_i;
  logic [FRAC_W-1:0] div_frac_i;
  logic              resync_i;
  logic              acq_o;
  logic              baud_o;
  logic              mid_o;
  logic [c_ph_w-1:0] phase_o;

  modport master (
    output en_i, div_int_i, div_frac_i, resync_i,
    input  acq_o, baud_o, mid_o, phase_o
  );

  modport slave (
    input  en_i, div_int_i, div_frac_i, resync_i,
    output acq_o, baud_o, mid_o, phase_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_frac_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_frac_baud_gen
// Brief    : Fractional (error-diffusing) acquisition/baud/mid-bit tick generator.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frac_baud_gen #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  uart_frac_baud_gen_if.slave    io
);
  localparam int                c_ph_w     = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [c_ph_w-1:0] c_ovs_last = c_ph_w'(OVS - 1);
  localparam logic [c_ph_w-1:0] c_ovs_mid  = c_ph_w'(OVS / 2 - 1);

  logic              en_q,    en_d;
  logic [DIV_W:0]    cnt_q,   cnt_d;
  logic [FRAC_W-1:0] acc_q,   acc_d;
  logic              carry_q, carry_d;
  logic [c_ph_w-1:0] ovs_q,   ovs_d;
  logic [DIV_W-1:0]  dint_q,  dint_d;
  logic [FRAC_W-1:0] dfrac_q, dfrac_d;
  logic              acq_q,   acq_d;
  logic              baud_q,  baud_d;
  logic              mid_q,   mid_d;

  logic [DIV_W-1:0]  w_div_in;
  logic [DIV_W:0]    w_term_cnt;
  logic              w_term;
  logic [FRAC_W:0]   w_sum;
  logic              w_last;

  // A zero integer divisor would give a 1-clock period; clamp to 1.
  assign w_div_in   = (io.div_int_i == '0) ? DIV_W'(1) : io.div_int_i;
  assign w_term_cnt = {1'b0, dint_q} + (DIV_W + 1)'(carry_q);
  assign w_term     = (cnt_q == w_term_cnt);
  assign w_sum      = {1'b0, acc_q} + {1'b0, dfrac_q};
  assign w_last     = (ovs_q == c_ovs_last);

  always_comb begin
    en_d    = io.en_i;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovs_d   = ovs_q;
    dint_d  = dint_q;
    dfrac_d = dfrac_q;
    acq_d   = 1'b0;
    baud_d  = 1'b0;
    mid_d   = 1'b0;

    if (!en_q) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      ovs_d   = '0;
      dint_d  = w_div_in;
      dfrac_d = io.div_frac_i;
    end else if (io.resync_i) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      ovs_d   = '0;
    end else if (w_term) begin
      cnt_d            = '0;
      {carry_d, acc_d} = w_sum;
      acq_d            = 1'b1;
      baud_d           = w_last;
      mid_d            = (ovs_q == c_ovs_mid);
      ovs_d            = w_last ? '0 : ovs_q + c_ph_w'(1);
      // Divisor shadows only move on a baud boundary so a bit never mixes periods.
      if (w_last) begin
        dint_d  = w_div_in;
        dfrac_d = io.div_frac_i;
      end
    end else begin
      cnt_d = cnt_q + (DIV_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      ovs_q   <= '0;
      dint_q  <= '0;
      dfrac_q <= '0;
      acq_q   <= 1'b0;
      baud_q  <= 1'b0;
      mid_q   <= 1'b0;
    end else begin
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      ovs_q   <= ovs_d;
      dint_q  <= dint_d;
      dfrac_q <= dfrac_d;
      acq_q   <= acq_d;
      baud_q  <= baud_d;
      mid_q   <= mid_d;
    end
  end

  assign io.acq_o   = acq_q;
  assign io.baud_o  = baud_q;
  assign io.mid_o   = mid_q;
  assign io.phase_o = ovs_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_frac_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frac_baud_gen
// Brief    : Scoreboard bench for the fractional baud tick generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frac_baud_gen;
  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OVS    = 8;

  typedef struct {
    int t;
    bit b;
    bit m;
    int ph;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   last_baud = -1;
  ev_t  sb[$];
  ev_t  mon_e;

  uart_frac_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) bus_if ();

  uart_frac_baud_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVS(OVS)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected acquisition ticks for a running generator started at edge t0.
  function automatic void push_train(input int t0, input int n, input int div,
                                     input int frac, input int ph0);
    int  t = t0;
    int  acc = 0;
    int  carry = 0;
    int  ph = ph0;
    ev_t e;
    for (int i = 0; i < n; i++) begin
      t    = t + div + 1 + carry;
      acc  = acc + frac;
      carry = (acc >= (1 << FRAC_W)) ? 1 : 0;
      acc  = acc % (1 << FRAC_W);
      e.t  = t;
      e.b  = (ph == OVS - 1);
      e.m  = (ph == OVS / 2 - 1);
      e.ph = (ph == OVS - 1) ? 0 : ph + 1;
      sb.push_back(e);
      ph = e.ph;
    end
  endfunction

  always @(negedge clk) begin
    if (bus_if.acq_o === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_acq: acq at cycle %0d, required no pulse", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc !== mon_e.t || bus_if.baud_o !== mon_e.b || bus_if.mid_o !== mon_e.m ||
            int'(bus_if.phase_o) !== mon_e.ph) begin
          n_err++;
          $display("FAIL acq_event: got t=%0d baud=%0b mid=%0b phase=%0d, required t=%0d baud=%0b mid=%0b phase=%0d",
                   cyc, bus_if.baud_o, bus_if.mid_o, bus_if.phase_o,
                   mon_e.t, mon_e.b, mon_e.m, mon_e.ph);
        end
      end
      if (bus_if.baud_o === 1'b1) last_baud = cyc;
    end else begin
      n_cmp++;
      if (bus_if.baud_o !== 1'b0 || bus_if.mid_o !== 1'b0) begin
        n_err++;
        $display("FAIL orphan_tick: cycle %0d baud=%0b mid=%0b without acq, required 0",
                 cyc, bus_if.baud_o, bus_if.mid_o);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) step();
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 2000 && cyc < target; i++) step();
  endtask

  // Disable, program the divisor, then enable; e0 is the edge where en_r rises.
  task automatic restart(input int div, input int frac, output int e0);
    bus_if.en_i = 1'b0;
    repeat (3) step();
    bus_if.div_int_i  = DIV_W'(div);
    bus_if.div_frac_i = FRAC_W'(frac);
    bus_if.en_i = 1'b1;
    e0 = cyc + 1;
  endtask

  task automatic test_reset();
    bus_if.en_i = 1'b0;
    bus_if.div_int_i = 16'd4;
    bus_if.div_frac_i = 4'd0;
    bus_if.resync_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus_if.acq_o, bus_if.baud_o, bus_if.mid_o} !== 3'b000 || bus_if.phase_o !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: acq/baud/mid=%b%b%b phase=%0d, required 000 phase=0",
               bus_if.acq_o, bus_if.baud_o, bus_if.mid_o, bus_if.phase_o);
    end
    repeat (3) step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_integer();
    int e0;
    restart(4, 0, e0);
    push_train(e0, 16, 4, 0, 0);
    wait_drain(200);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL integer_drain: %0d ticks missing, required 0", sb.size());
      sb.delete();
    end
    n_cmp++;
    if (last_baud - e0 !== 80) begin
      n_err++;
      $display("FAIL integer_baud: second baud at +%0d, required +80", last_baud - e0);
    end
  endtask

  task automatic test_frac();
    int e0;
    restart(4, 8, e0);
    push_train(e0, 16 * OVS, 4, 8, 0);
    wait_drain(900);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL frac_drain: %0d ticks missing, required 0", sb.size());
      sb.delete();
    end
    n_cmp++;
    if (last_baud - e0 < 703 || last_baud - e0 > 705) begin
      n_err++;
      $display("FAIL frac_16baud: 16 baud periods took %0d, required 704 +/-1", last_baud - e0);
    end
  endtask

  task automatic test_resync();
    int e0;
    int r;
    restart(4, 0, e0);
    r = e0 + 15;
    push_train(e0, 2, 4, 0, 0);
    push_train(r, 8, 4, 0, 0);
    wait_cyc(r - 1);
    bus_if.resync_i = 1'b1;
    step();
    bus_if.resync_i = 1'b0;
    n_cmp++;
    if (bus_if.acq_o !== 1'b0 || bus_if.phase_o !== '0) begin
      n_err++;
      $display("FAIL resync_edge: acq=%0b phase=%0d, required acq=0 phase=0",
               bus_if.acq_o, bus_if.phase_o);
    end
    wait_drain(100);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL resync_drain: %0d ticks missing, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_div_change();
    int e0;
    restart(4, 0, e0);
    push_train(e0, OVS, 4, 0, 0);
    push_train(e0 + 40, OVS, 9, 0, 0);
    wait_cyc(e0 + 15);
    n_cmp++;
    if (bus_if.phase_o !== 3'd3) begin
      n_err++;
      $display("FAIL divchg_phase: phase=%0d, required 3", bus_if.phase_o);
    end
    bus_if.div_int_i = 16'd9;
    wait_drain(200);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL divchg_drain: %0d ticks missing, required 0", sb.size());
      sb.delete();
    end
    bus_if.div_int_i = 16'd4;
  endtask

  task automatic test_enable();
    int e0;
    restart(4, 0, e0);
    push_train(e0, 3, 4, 0, 0);
    wait_cyc(e0 + 17);
    bus_if.en_i = 1'b0;
    step();
    step();
    n_cmp++;
    if ({bus_if.acq_o, bus_if.baud_o, bus_if.mid_o} !== 3'b000 || bus_if.phase_o !== '0) begin
      n_err++;
      $display("FAIL disable_clear: acq/baud/mid=%b%b%b phase=%0d, required 000 phase=0",
               bus_if.acq_o, bus_if.baud_o, bus_if.mid_o, bus_if.phase_o);
    end
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL disable_drain: %0d ticks missing, required 0", sb.size());
      sb.delete();
    end
    repeat (5) step();
    bus_if.en_i = 1'b1;
    e0 = cyc + 1;
    push_train(e0, OVS, 4, 0, 0);
    wait_drain(100);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL reenable_drain: %0d ticks missing, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_async_rst();
    int e0;
    restart(4, 0, e0);
    push_train(e0, 2, 4, 0, 0);
    wait_drain(50);
    bus_if.div_int_i = 16'd0;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus_if.acq_o, bus_if.baud_o, bus_if.mid_o} !== 3'b000 || bus_if.phase_o !== '0) begin
      n_err++;
      $display("FAIL async_rst: acq/baud/mid=%b%b%b phase=%0d, required 000 phase=0",
               bus_if.acq_o, bus_if.baud_o, bus_if.mid_o, bus_if.phase_o);
    end
    bus_if.en_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    bus_if.en_i = 1'b1;
    e0 = cyc + 1;
    // A zero divisor is clamped to 1, giving a 2-clock period.
    push_train(e0, 2 * OVS, 1, 0, 0);
    wait_drain(100);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL clamp_drain: %0d ticks missing, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_integer();
    test_frac();
    test_resync();
    test_div_change();
    test_enable();
    test_async_rst();
    bus_if.en_i = 1'b0;
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
